eth_pkt_arb: RTL and testbench

Parametrised N-port packet arbiter for the ethernet switch. It merges NUM_PORTS sop/eop framed input streams onto one output stream. Arbitration is round-robin at packet granularity, so a packet is never interleaved with another. Backpressure runs in both directions: a per-port input stall and a downstream output stall. The block sits in front of each switch egress port and generalises the fixed two-port (A/B) datapath to N ports and arbitrary width, adding framing-error counting and packet counting.

---
 rtl/eth_pkt_arb.sv | 178 +++++++++++++++++
 tb/tb_eth_pkt_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pkt_arb.sv
// rtl/eth_pkt_arb.sv - round-robin packet arbiter merging N framed input streams
//
// Purpose: merges NUM_PORTS sop/eop framed input streams onto one output
// stream. Arbitration is round-robin per packet, so packets never interleave.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   inValid/inSop/inEop    per-port word valid and framing flags
//   inData                 port i at [i*DATA_W +: DATA_W]
//   inStall                per-port backpressure (word accepted when valid && !stall)
//   outValid/outData       registered output word
//   outSop/outEop          registered output framing flags
//   outStall               downstream backpressure, output held while high
//   grantPort              port currently granted (meaningful in XFER)
//   pktCnt/errCnt          saturating packet and framing-error counters
module eth_pkt_arb #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int EW       = $clog2(NUM_PORTS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        inValid,
  input  logic [NUM_PORTS*DATA_W-1:0] inData,
  input  logic [NUM_PORTS-1:0]        inSop,
  input  logic [NUM_PORTS-1:0]        inEop,
  output logic [NUM_PORTS-1:0]        inStall,
  output logic                        outValid,
  output logic [DATA_W-1:0]           outData,
  output logic                        outSop,
  output logic                        outEop,
  input  logic                        outStall,
  output logic [PW-1:0]               grantPort,
  output logic [CNT_W-1:0]            pktCnt,
  output logic [CNT_W-1:0]            errCnt
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                state;
  state_t                nextState;
  logic [PW-1:0]         rrLast;
  logic                  firstWord;
  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  stray;
  logic                  grantFound;
  logic [PW-1:0]         grantIdx;
  logic [PW-1:0]         cand;
  logic                  accept;
  logic [DATA_W-1:0]     gData;
  logic                  gSop;
  logic                  gEop;
  logic [EW-1:0]         errInc;
  logic [CNT_W:0]        errSum;
  logic [CNT_W-1:0]      errNext;

  assign req = inValid & inSop;

  // Round-robin search starting just after the last granted port.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = PW'((int'(rrLast) + k) % NUM_PORTS);
      if (!grantFound && req[cand]) begin
        grantFound = 1'b1;
        grantIdx   = cand;
      end
    end
  end

  // Granted-port mux.
  always_comb begin
    gData = '0;
    gSop  = 1'b0;
    gEop  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grantPort == PW'(i)) begin
        gData = inData[i*DATA_W +: DATA_W];
        gSop  = inSop[i];
        gEop  = inEop[i];
      end
    end
  end

  // Next state and per-port stalls. In IDLE, sop words wait for their grant
  // while stray non-sop words are drained so they cannot block arbitration.
  always_comb begin
    nextState = state;
    inStall   = '1;
    stray     = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        stray   = inValid & ~inSop;
        inStall = ~stray;
        if (grantFound) begin
          nextState = XFER;
        end
      end
      XFER: begin
        // Combinational stall path keeps the output register skid-free.
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (grantPort == PW'(i)) begin
            inStall[i] = outStall;
          end
        end
        accept = inValid[grantPort] & ~outStall;
        if (accept && gEop) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Framing errors this cycle: drained strays in IDLE, or a repeated sop
  // inside a packet in XFER. The two never occur in the same cycle.
  always_comb begin
    errInc = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      errInc = errInc + EW'(stray[i]);
    end
    if (accept && gSop && !firstWord) begin
      errInc = errInc + EW'(1);
    end
    errSum  = {1'b0, errCnt} + (CNT_W+1)'(errInc);
    errNext = errSum[CNT_W] ? '1 : errSum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grantPort <= '0;
      rrLast    <= PW'(NUM_PORTS - 1);
      firstWord <= 1'b0;
      outValid  <= 1'b0;
      outData   <= '0;
      outSop    <= 1'b0;
      outEop    <= 1'b0;
      pktCnt    <= '0;
      errCnt    <= '0;
    end else begin
      if (state == IDLE && grantFound) begin
        grantPort <= grantIdx;
        rrLast    <= grantIdx;
        firstWord <= 1'b1;
      end

      if (accept) begin
        outValid  <= 1'b1;
        outData   <= gData;
        outSop    <= gSop & firstWord;
        outEop    <= gEop;
        firstWord <= 1'b0;
      end else if (!outStall) begin
        outValid  <= 1'b0;
      end

      if (outValid && outEop && !outStall && (pktCnt != '1)) begin
        pktCnt <= pktCnt + 1'b1;
      end

      errCnt <= errNext;
    end
  end

endmodule

// File: tb/tb_eth_pkt_arb.sv
// tb/tb_eth_pkt_arb.sv - scoreboard bench for eth_pkt_arb
module tb_eth_pkt_arb;

  localparam int NP   = 4;
  localparam int DW   = 16;
  localparam int CW   = 4;
  localparam int PW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NP-1:0]        inValid, inSop, inEop, inStall;
  logic [NP*DW-1:0]     inData;
  logic                 outValid, outSop, outEop, outStall;
  logic [DW-1:0]        outData;
  logic [PW-1:0]        grantPort;
  logic [CW-1:0]        pktCnt, errCnt;

  always #5 clk = ~clk;

  eth_pkt_arb #(.NUM_PORTS(NP), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .inValid(inValid), .inData(inData), .inSop(inSop), .inEop(inEop),
    .inStall(inStall),
    .outValid(outValid), .outData(outData), .outSop(outSop), .outEop(outEop),
    .outStall(outStall), .grantPort(grantPort),
    .pktCnt(pktCnt), .errCnt(errCnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } word_t;

  word_t      srcQ[NP][$];
  word_t      expQ[$];
  bit         presenting[NP];
  int         waitCnt[NP];
  int         errors = 0;
  int         checks = 0;

  // Reference model: arbiter busy flag, owner, last grant, counters.
  bit         mBusy, mFirst, mOutValid, mOutEop;
  int         mOwner, mRr, mPkt, mErr;

  int         testCyc, rstAt, stallFrom, stallTo, stallPct, maxGap;
  bit         rstReq = 1'b0;
  bit         clearPending = 1'b0;
  logic [DW-1:0] expHeldWord = '0;
  int         heldStallCycles = 0;
  logic [3:0] sopPorts[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mBusy = 0; mFirst = 0; mOutValid = 0; mOutEop = 0;
    mOwner = 0; mRr = NP - 1; mPkt = 0; mErr = 0;
    clearPending = 1'b1;
    for (int i = 0; i < NP; i++) begin
      srcQ[i].delete();
      presenting[i] = 0;
      waitCnt[i] = 0;
    end
  endtask

  task automatic addWord(int p, logic [DW-1:0] d, logic s, logic e);
    word_t w;
    w.data = d; w.sop = s; w.eop = e;
    srcQ[p].push_back(w);
  endtask

  task automatic addPkt(int p, logic [DW-1:0] base, int len);
    for (int j = 0; j < len; j++) addWord(p, base + DW'(j), j == 0, j == len - 1);
  endtask

  task automatic startTest();
    testCyc = 0; rstAt = -1; stallFrom = 0; stallTo = 0; stallPct = 0; maxGap = 0;
  endtask

  // One clock cycle: check registered outputs against the model, drive new
  // inputs, check stalls, then advance model and sources for the coming edge.
  task automatic stepCycle();
    logic [NP-1:0] expStall;
    bit            acc, pktInc, found;
    int            g;
    word_t         w;
    @(negedge clk);
    if (clearPending) begin
      expQ.delete();
      clearPending = 1'b0;
    end
    check("outValid", outValid, mOutValid);
    check("pktCnt", pktCnt, mPkt);
    check("errCnt", errCnt, mErr);
    if (mBusy) check("grantPort", grantPort, mOwner);
    reset = rstReq || (testCyc == rstAt);
    outStall = ((testCyc >= stallFrom && testCyc < stallTo) ||
                ($urandom_range(0, 99) < stallPct)) ? 1'b1 : 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (!presenting[i] && srcQ[i].size() > 0) begin
        if (waitCnt[i] > 0) waitCnt[i]--;
        else presenting[i] = 1;
      end
      inValid[i]          = presenting[i];
      inData[i*DW +: DW]  = presenting[i] ? srcQ[i][0].data : '0;
      inSop[i]            = presenting[i] && srcQ[i][0].sop;
      inEop[i]            = presenting[i] && srcQ[i][0].eop;
    end
    #1;
    for (int i = 0; i < NP; i++) begin
      if (!mBusy) expStall[i] = !(inValid[i] && !inSop[i]);
      else        expStall[i] = (i == mOwner) ? outStall : 1'b1;
    end
    check("inStall", inStall, expStall);
    if (reset) begin
      modelReset();
    end else begin
      pktInc = mOutValid && mOutEop && !outStall;
      acc = 0;
      if (!mBusy) begin
        for (int i = 0; i < NP; i++)
          if (inValid[i] && !inSop[i] && mErr < CMAX) mErr++;
        found = 0;
        for (int k = 1; k <= NP; k++) begin
          g = (mRr + k) % NP;
          if (!found && inValid[g] && inSop[g]) begin
            found = 1; mBusy = 1; mOwner = g; mRr = g; mFirst = 1;
          end
        end
      end else if (inValid[mOwner] && !outStall) begin
        acc = 1;
        w.data = inData[mOwner*DW +: DW];
        w.sop  = inSop[mOwner] && mFirst;
        w.eop  = inEop[mOwner];
        expQ.push_back(w);
        if (inSop[mOwner] && !mFirst && mErr < CMAX) mErr++;
        mFirst  = 0;
        mOutEop = inEop[mOwner];
        if (inEop[mOwner]) mBusy = 0;
      end
      if (acc) mOutValid = 1;
      else if (!outStall) mOutValid = 0;
      if (pktInc && mPkt < CMAX) mPkt++;
      for (int i = 0; i < NP; i++) begin
        if (inValid[i] && !expStall[i]) begin
          void'(srcQ[i].pop_front());
          presenting[i] = 0;
          waitCnt[i] = $urandom_range(0, maxGap);
        end
      end
    end
    testCyc++;
  endtask

  function automatic bit srcEmpty();
    for (int i = 0; i < NP; i++) if (srcQ[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drain(int budget);
    int n = 0;
    while (n < budget && !(srcEmpty() && !mBusy && !mOutValid && expQ.size() == 0)) begin
      stepCycle();
      n++;
    end
    check("drainWithinBudget", n < budget, 1);
    stepCycle();
    stepCycle();
  endtask

  task automatic doReset();
    rstReq = 1'b1;
    stepCycle();
    rstReq = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a word leaves, checks output hold
  // under outStall and source stability under inStall.
  initial begin
    logic          pv, ps, pr, psop, peop;
    logic [DW-1:0] pd;
    logic [NP-1:0] piv, pis;
    logic [NP*DW-1:0] pid;
    word_t         w;
    pv = 0; ps = 0; pr = 1; psop = 0; peop = 0; pd = '0;
    piv = '0; pis = '0; pid = '0;
    forever begin
      @(negedge clk);
      #2;
      if (pv && ps && !pr) begin
        check("holdValid", outValid, 1);
        check("holdData", outData, pd);
        check("holdSop", outSop, psop);
        check("holdEop", outEop, peop);
      end
      for (int i = 0; i < NP; i++) begin
        if (piv[i] && pis[i] && !pr) begin
          check("srcHoldValid", inValid[i], 1);
          check("srcHoldData", inData[i*DW +: DW], pid[i*DW +: DW]);
        end
      end
      if (outValid && !outStall) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpectedWord: got 0x%0h expected no word", outData);
        end else begin
          w = expQ.pop_front();
          check("outData", outData, w.data);
          check("outSop", outSop, w.sop);
          check("outEop", outEop, w.eop);
          if (outSop) sopPorts.push_back(outData[15:12]);
        end
      end
      if (outValid && outStall && outData == expHeldWord) heldStallCycles++;
      pv = outValid; ps = outStall; pr = reset; pd = outData;
      psop = outSop; peop = outEop;
      piv = inValid; pis = inStall; pid = inData;
    end
  end

  initial begin
    int len, p;
    logic [DW-1:0] d;
    reset = 1'b1; outStall = 1'b0;
    inValid = '0; inSop = '0; inEop = '0; inData = '0;
    startTest();
    repeat (2) @(posedge clk);
    modelReset();
    clearPending = 1'b0;
    @(negedge clk);
    check("rstOutValid", outValid, 0);
    check("rstOutData", outData, 0);
    check("rstOutSop", outSop, 0);
    check("rstOutEop", outEop, 0);
    check("rstGrantPort", grantPort, 0);
    check("rstPktCnt", pktCnt, 0);
    check("rstErrCnt", errCnt, 0);

    // Basic 4-word packet on port 0.
    startTest();
    addPkt(0, 16'h0011, 4);
    drain(200);
    check("t1PktCnt", pktCnt, 1);
    check("t1ErrCnt", errCnt, 0);

    // Round-robin order with immediate refill on port 0.
    doReset();
    startTest();
    addPkt(0, 16'h0100, 2);
    addPkt(0, 16'h0200, 2);
    addPkt(1, 16'h1100, 2);
    addPkt(2, 16'h2100, 2);
    sopPorts.delete();
    drain(200);
    check("t2PktCnt", pktCnt, 4);
    check("t2NumPkts", sopPorts.size(), 4);
    if (sopPorts.size() == 4) begin
      check("t2Order0", sopPorts[0], 0);
      check("t2Order1", sopPorts[1], 1);
      check("t2Order2", sopPorts[2], 2);
      check("t2Order3", sopPorts[3], 0);
    end

    // Downstream stall for 3 cycles while the 2nd word is on the output.
    doReset();
    startTest();
    addPkt(3, 16'h3001, 8);
    expHeldWord = 16'h3002;
    heldStallCycles = 0;
    stallFrom = 3; stallTo = 6;
    drain(200);
    check("t3HeldCycles", heldStallCycles, 3);
    check("t3PktCnt", pktCnt, 1);

    // Single-word packet.
    doReset();
    startTest();
    addWord(1, 16'h00AB, 1, 1);
    drain(200);
    check("t4PktCnt", pktCnt, 1);
    check("t4ErrCnt", errCnt, 0);

    // Stray word in IDLE and a repeated sop inside a packet.
    doReset();
    startTest();
    addWord(2, 16'h0055, 0, 0);
    addWord(2, 16'h2001, 1, 0);
    addWord(2, 16'h2002, 1, 0);
    addWord(2, 16'h2003, 0, 1);
    drain(200);
    check("t5ErrCnt", errCnt, 2);
    check("t5PktCnt", pktCnt, 1);

    // Reset during word 3 of a 6-word packet, then a normal packet on port 1.
    doReset();
    startTest();
    addPkt(0, 16'h0061, 6);
    rstAt = 3;
    repeat (5) stepCycle();
    check("t6OutValid", outValid, 0);
    check("t6PktCnt", pktCnt, 0);
    check("t6ErrCnt", errCnt, 0);
    addPkt(1, 16'h1071, 2);
    drain(200);
    check("t6PktCntAfter", pktCnt, 1);

    // Counter saturation.
    doReset();
    startTest();
    for (int n = 0; n < 20; n++) begin
      addPkt(1, 16'h1000 + DW'(n), 1);
      addWord(2, 16'h2000 + DW'(n), 0, 0);
    end
    drain(2000);
    check("t7PktSat", pktCnt, CMAX);
    check("t7ErrSat", errCnt, CMAX);

    // Randomised traffic with gaps, strays, repeated sops and output stalls.
    doReset();
    startTest();
    stallPct = 25;
    maxGap = 3;
    for (int n = 0; n < 40; n++) begin
      p = int'($urandom_range(0, NP - 1));
      if ($urandom_range(0, 9) == 0) addWord(p, {p[3:0], 12'hFFF}, 0, $urandom_range(0, 1) == 1);
      len = int'($urandom_range(1, 5));
      for (int j = 0; j < len; j++) begin
        d = {p[3:0], 12'(n * 8 + j)};
        addWord(p, d, (j == 0) || (j > 0 && j < len - 1 && $urandom_range(0, 9) == 0), j == len - 1);
      end
    end
    drain(20000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
